// File: rtl/pf_ddr4_lane_rx_bitslip_ctrl.sv
// Read-training word aligner for one DDR4 DQ/DM lane: slips the RX IOD until PATTERN locks.
// Optional post-lock mismatch counter on ERR_CNT is built only when PF_DDR4_RX_ERR_CNT_EN is defined.
module pf_ddr4_lane_rx_bitslip_ctrl #(
  parameter logic [7:0] PATTERN    = 8'h0F,
  parameter int         MATCH_CNT  = 8,
  parameter int         SETTLE_CYC = 4,
  parameter int         MAX_SLIP   = 7
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA_IN,
  input  logic       RX_VALID,
  output logic       RX_BIT_SLIP,
  output logic       LOCKED,
  output logic       FAIL,
  output logic       BUSY,
  output logic [2:0] SLIP_COUNT,
  output logic [7:0] RX_DATA_OUT,
  output logic       RX_DATA_OUT_VALID,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCK,
    ST_FAIL
  } state_t;

  localparam logic [7:0] MATCH_TGT   = 8'(MATCH_CNT);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [2:0] SLIP_MAX    = 3'(MAX_SLIP);

  // Reset asserts immediately but releases only on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) rst_pipe <= 2'b00;
    else         rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  state_t     state_q, state_d;
  logic [7:0] match_q, match_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] slip_q, slip_d;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge FAB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      match_q  <= 8'd0;
      settle_q <= 4'd0;
      slip_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      settle_q <= settle_d;
      slip_q   <= slip_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    settle_d = settle_q;
    slip_d   = slip_q;
    if (TRAIN_START) begin
      state_d  = ST_CHECK;
      match_d  = 8'd0;
      settle_d = 4'd0;
      slip_d   = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_CHECK: begin
          // Lock is taken on the cycle after the final match has been counted.
          if (match_q == MATCH_TGT) begin
            state_d = ST_LOCK;
          end else if (RX_VALID) begin
            if (RX_DATA_IN == PATTERN) begin
              match_d = match_q + 8'd1;
            end else begin
              match_d = 8'd0;
              state_d = (slip_q == SLIP_MAX) ? ST_FAIL : ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          slip_d   = slip_q + 3'd1;
          settle_d = 4'd0;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = 4'd0;
            match_d  = 8'd0;
            state_d  = ST_CHECK;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        ST_LOCK: ;
        ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign RX_BIT_SLIP = (state_q == ST_SLIP);
  assign LOCKED      = (state_q == ST_LOCK);
  assign FAIL        = (state_q == ST_FAIL);
  assign BUSY        = (state_q == ST_CHECK) || (state_q == ST_SLIP) || (state_q == ST_SETTLE);
  assign SLIP_COUNT  = slip_q;

  // Valid is suppressed when a restart is leaving LOCK so it never shows outside LOCK.
  always_ff @(posedge FAB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      RX_DATA_OUT       <= 8'd0;
      RX_DATA_OUT_VALID <= 1'b0;
    end else begin
      if (state_q == ST_LOCK) RX_DATA_OUT <= RX_DATA_IN;
      RX_DATA_OUT_VALID <= (state_q == ST_LOCK) && RX_VALID && !TRAIN_START;
    end
  end

`ifdef PF_DDR4_RX_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge FAB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else if (TRAIN_START) begin
      err_q <= 8'd0;
    end else if ((state_q == ST_LOCK) && RX_VALID && (RX_DATA_IN != PATTERN) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign ERR_CNT = err_q;
`else
  assign ERR_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_pf_ddr4_lane_rx_bitslip_ctrl.sv
// Directed bench for pf_ddr4_lane_rx_bitslip_ctrl with a rotating IOD model and
// hand-computed expectations; honours PF_DDR4_RX_ERR_CNT_EN for the ERR_CNT check.
module tb_pf_ddr4_lane_rx_bitslip_ctrl;

  localparam logic [7:0] PAT = 8'h0F;

  logic       FAB_CLK;
  logic       ARST_N;
  logic       TRAIN_START;
  logic [7:0] RX_DATA_IN;
  logic       RX_VALID;
  logic       RX_BIT_SLIP;
  logic       LOCKED;
  logic       FAIL;
  logic       BUSY;
  logic [2:0] SLIP_COUNT;
  logic [7:0] RX_DATA_OUT;
  logic       RX_DATA_OUT_VALID;
  logic [7:0] ERR_CNT;

  int total = 0;
  int bad   = 0;

  // IOD model: each sampled slip pulse shifts the word boundary back by one bit.
  logic       load_req = 1'b0;
  int         load_off = 0;
  logic       use_model = 1'b1;
  logic [7:0] manual_word = 8'h00;
  int         offset = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         last_slip = -100;
  int         min_gap = 1000;

  pf_ddr4_lane_rx_bitslip_ctrl dut (
    .FAB_CLK          (FAB_CLK),
    .ARST_N           (ARST_N),
    .TRAIN_START      (TRAIN_START),
    .RX_DATA_IN       (RX_DATA_IN),
    .RX_VALID         (RX_VALID),
    .RX_BIT_SLIP      (RX_BIT_SLIP),
    .LOCKED           (LOCKED),
    .FAIL             (FAIL),
    .BUSY             (BUSY),
    .SLIP_COUNT       (SLIP_COUNT),
    .RX_DATA_OUT      (RX_DATA_OUT),
    .RX_DATA_OUT_VALID(RX_DATA_OUT_VALID),
    .ERR_CNT          (ERR_CNT)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [15:0] w;
    w = {v, v} << k;
    return w[15:8];
  endfunction

  assign RX_DATA_IN = use_model ? rotl(PAT, offset) : manual_word;

  always @(posedge FAB_CLK) begin
    cyc <= cyc + 1;
    if (load_req) begin
      offset    <= load_off;
      pulses    <= 0;
      last_slip <= -100;
      min_gap   <= 1000;
    end else if (RX_BIT_SLIP) begin
      offset    <= (offset + 7) % 8;
      pulses    <= pulses + 1;
      last_slip <= cyc;
      if (cyc - last_slip < min_gap) min_gap <= cyc - last_slip;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic start_pass(input logic load, input int off);
    load_req    = load;
    load_off    = off;
    TRAIN_START = 1'b1;
    tick();
    TRAIN_START = 1'b0;
    load_req    = 1'b0;
  endtask

  initial begin
    ARST_N      = 1'b1;
    TRAIN_START = 1'b0;
    RX_VALID    = 1'b0;
    #2 ARST_N = 1'b0;
    #20;
    check("rst_locked", LOCKED, 0);
    check("rst_fail", FAIL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_slip", RX_BIT_SLIP, 0);
    check("rst_slip_count", SLIP_COUNT, 0);
    check("rst_data_out", RX_DATA_OUT, 0);
    check("rst_data_valid", RX_DATA_OUT_VALID, 0);
    check("rst_err_cnt", ERR_CNT, 0);
    tick();
    ARST_N = 1'b1;
    repeat (3) tick();
    check("idle_busy", BUSY, 0);

    // Aligned data: lock lands MATCH_CNT+1 cycles after entering CHECK.
    use_model = 1'b1;
    RX_VALID  = 1'b1;
    start_pass(1'b1, 0);
    check("t1_busy", BUSY, 1);
    repeat (8) tick();
    check("t1_not_yet_locked", LOCKED, 0);
    tick();
    check("t1_locked", LOCKED, 1);
    check("t1_busy_off", BUSY, 0);
    check("t1_slip_count", SLIP_COUNT, 0);
    check("t1_pulses", pulses, 0);
    tick();
    check("t1_data_out", RX_DATA_OUT, 8'h0F);
    check("t1_data_valid", RX_DATA_OUT_VALID, 1);

    // Offset 3: three slips, each at least SETTLE_CYC+1 cycles apart.
    start_pass(1'b1, 3);
    for (int i = 0; i < 200 && !LOCKED; i++) tick();
    check("t2_locked", LOCKED, 1);
    check("t2_slip_count", SLIP_COUNT, 3);
    check("t2_pulses", pulses, 3);
    check("t2_gap_ok", (min_gap >= 5), 1);
    check("t2_fail", FAIL, 0);
    tick();
    check("t2_data_out", RX_DATA_OUT, 8'h0F);
    check("t2_valid_hi", RX_DATA_OUT_VALID, 1);
    RX_VALID = 1'b0;
    tick();
    check("t2_valid_lo", RX_DATA_OUT_VALID, 0);
    RX_VALID = 1'b1;
    tick();
    check("t2_valid_back", RX_DATA_OUT_VALID, 1);
    check("t2_data_out2", RX_DATA_OUT, 8'h0F);

    // Constant zero: seven slips then FAIL, held until restart.
    use_model   = 1'b0;
    manual_word = 8'h00;
    start_pass(1'b1, 0);
    for (int i = 0; i < 300 && !FAIL; i++) tick();
    check("t3_fail", FAIL, 1);
    check("t3_locked", LOCKED, 0);
    check("t3_busy", BUSY, 0);
    check("t3_slip_count", SLIP_COUNT, 7);
    check("t3_pulses", pulses, 7);
    repeat (20) tick();
    check("t3_fail_held", FAIL, 1);
    check("t3_count_held", SLIP_COUNT, 7);
    check("t3_pulses_held", pulses, 7);
    check("t3_valid_out", RX_DATA_OUT_VALID, 0);

    // 50% RX_VALID: invalid cycles carry garbage and must neither count nor reset.
    RX_VALID = 1'b0;
    start_pass(1'b1, 0);
    for (int k = 0; k < 16; k++) begin
      RX_VALID    = (k % 2 == 0);
      manual_word = RX_VALID ? PAT : 8'h00;
      tick();
      if (k == 14) begin
        check("t4_not_yet_locked", LOCKED, 0);
        check("t4_busy", BUSY, 1);
      end
    end
    check("t4_locked", LOCKED, 1);
    check("t4_slip_count", SLIP_COUNT, 0);
    check("t4_pulses", pulses, 0);

    // Mismatches after lock: LOCKED holds, ERR_CNT saturates only when built in.
    RX_VALID    = 1'b1;
    manual_word = 8'hAA;
    repeat (300) tick();
    check("t6_locked", LOCKED, 1);
`ifdef PF_DDR4_RX_ERR_CNT_EN
    check("t6_err_sat", ERR_CNT, 8'hFF);
    start_pass(1'b0, 0);
    check("t6_err_clr", ERR_CNT, 8'h00);
`else
    check("t6_err_zero", ERR_CNT, 8'h00);
`endif

    // Restart mid-SETTLE after two slips; new pass searches from the current offset.
    use_model = 1'b1;
    start_pass(1'b1, 3);
    for (int i = 0; i < 100 && SLIP_COUNT != 3'd2; i++) tick();
    check("t5_two_slips", SLIP_COUNT, 2);
    check("t5_in_settle", BUSY, 1);
    check("t5_no_pulse", RX_BIT_SLIP, 0);
    start_pass(1'b0, 0);
    check("t5_count_clr", SLIP_COUNT, 0);
    check("t5_check_busy", BUSY, 1);
    check("t5_no_pulse2", RX_BIT_SLIP, 0);
    for (int i = 0; i < 100 && !LOCKED; i++) tick();
    check("t5_locked", LOCKED, 1);
    check("t5_slip_count", SLIP_COUNT, 1);
    tick();
    check("t5_valid_pre_rst", RX_DATA_OUT_VALID, 1);

    #3 ARST_N = 1'b0;
    #1;
    check("t5_rst_locked", LOCKED, 0);
    check("t5_rst_busy", BUSY, 0);
    check("t5_rst_count", SLIP_COUNT, 0);
    check("t5_rst_data", RX_DATA_OUT, 0);
    check("t5_rst_valid", RX_DATA_OUT_VALID, 0);
    check("t5_rst_err", ERR_CNT, 0);
    tick();
    ARST_N = 1'b1;
    repeat (4) tick();
    check("t5_post_rst_idle", BUSY, 0);
    check("t5_post_rst_unlocked", LOCKED, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pf_ddr4_lane_rx_bitslip_ctrl.md
Name: pf_ddr4_lane_rx_bitslip_ctrl

Overview:
- Receive-direction companion to the DDR4 lane TX IODs; runs read-training word alignment for one DQ/DM lane.
- Monitors the 8-bit deserialized RX_DATA from the lane IOD and checks it against a known training pattern.
- Issues single-cycle RX_BIT_SLIP pulses to the IOD until the word boundary is aligned, then reports lock and forwards aligned data to the fabric.
- Sits in the FAB_CLK domain between the IOD RX_DATA/RX_BIT_SLIP pins and the training sequencer.

Parameters:
- PATTERN, 8'h0F, expected training word; all 8 rotations must be distinct.
- MATCH_CNT, 8, consecutive matching valid words required for lock (1..255).
- SETTLE_CYC, 4, FAB_CLK cycles to wait after a slip pulse before re-checking (1..15).
- MAX_SLIP, 7, slips allowed before FAIL (0..7).

Ports:
- FAB_CLK  in  1  fabric clock, all logic rising-edge.
- ARST_N  in  1  asynchronous active-low reset.
- TRAIN_START  in  1  pulse; starts or restarts training.
- RX_DATA_IN  in  8  deserialized word from IOD RX_DATA[7:0].
- RX_VALID  in  1  RX_DATA_IN qualifier.
- RX_BIT_SLIP  out  1  to IOD; one-cycle pulse per slip.
- LOCKED  out  1  alignment achieved.
- FAIL  out  1  MAX_SLIP exhausted without lock.
- BUSY  out  1  training in progress (CHECK/SLIP/SETTLE).
- SLIP_COUNT  out  3  slips issued in the current training pass.
- RX_DATA_OUT  out  8  registered aligned data.
- RX_DATA_OUT_VALID  out  1  RX_VALID delayed 1 cycle, gated by LOCKED.
- ERR_CNT  out  8  post-lock mismatch count (optional feature).

Behaviour:
- ARST_N low: state IDLE; all outputs 0; internal match/settle counters 0. Asserts asynchronously; deasserts synchronously to FAB_CLK.
- FSM states: IDLE, CHECK, SLIP, SETTLE, LOCK, FAIL.
- IDLE: TRAIN_START → CHECK. Clear SLIP_COUNT, match_cnt, LOCKED, FAIL.
- CHECK (BUSY=1): evaluated only on RX_VALID=1 cycles; RX_VALID=0 holds all state.
  - RX_DATA_IN==PATTERN: match_cnt++. On reaching MATCH_CNT → LOCK; LOCKED=1 next cycle.
  - Mismatch: match_cnt=0. If SLIP_COUNT==MAX_SLIP → FAIL, else → SLIP.
- SLIP: RX_BIT_SLIP=1 for exactly this one cycle; SLIP_COUNT++; → SETTLE.
- SETTLE: count SETTLE_CYC cycles, ignoring RX data, then → CHECK with match_cnt=0. Successive slip pulses are therefore at least SETTLE_CYC+1 cycles apart.
- LOCK:
  - LOCKED=1, BUSY=0.
  - RX_DATA_OUT <= RX_DATA_IN every cycle; RX_DATA_OUT_VALID <= RX_VALID. Latency 1 cycle.
  - RX_DATA_OUT_VALID is 0 in every state other than LOCK.
- FAIL: FAIL=1, BUSY=0. Hold until TRAIN_START.
- TRAIN_START in any state (including mid-CHECK/SLIP/SETTLE): → CHECK next cycle.
  - Clears LOCKED, FAIL, SLIP_COUNT, match_cnt and ERR_CNT.
  - An in-progress SLIP pulse is not extended.
  - The IOD's physical slip position is not undone; the new pass searches from the current alignment.
- TRAIN_START asserted in the same cycle as a CHECK-state transition: TRAIN_START wins.
- MAX_SLIP=0: first mismatch → FAIL with no slip pulse.
- SLIP_COUNT never wraps; it is bounded by MAX_SLIP ≤ 7.

Optional Feature:
- Macro: PF_DDR4_RX_ERR_CNT_EN.
- Defined: in LOCK, each RX_VALID word != PATTERN increments ERR_CNT. ERR_CNT saturates at 8'hFF; it is cleared by reset or TRAIN_START; LOCKED is unaffected.
- Undefined: ERR_CNT tied to 8'h00 and no counter logic is present.

Test Plan:
- Aligned input (bench feeds 8'h0F continuously, RX_VALID=1), TRAIN_START → LOCKED=1 exactly MATCH_CNT+1 cycles after CHECK entry; SLIP_COUNT=0; no RX_BIT_SLIP pulse.
- Bench IOD model rotates data 1 bit per slip, initial offset 3 → exactly 3 RX_BIT_SLIP pulses, each ≥5 cycles apart; LOCKED=1; SLIP_COUNT=3; RX_DATA_OUT=8'h0F one cycle after each valid input.
- Constant 8'h00 input → 7 slips, then FAIL=1, LOCKED=0, BUSY=0, SLIP_COUNT=7; state held until TRAIN_START.
- RX_VALID toggled 50% during CHECK with aligned data → lock only after 8 valid matches; invalid cycles neither count nor reset match_cnt.
- TRAIN_START issued during SETTLE after 2 slips → SLIP_COUNT=0 next cycle, CHECK entered, training completes from the new alignment. ARST_N pulsed mid-LOCK → all outputs 0 immediately.
- With PF_DDR4_RX_ERR_CNT_EN: after lock, inject 300 mismatching words → ERR_CNT=8'hFF, LOCKED stays 1. Without the macro: ERR_CNT=0.
